// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch front end of the pipelined RV32I core. Keeps the fetch
// PC, keeps at most one request outstanding to instruction memory, and
// holds the fetched word with its PC for the decode stage. A taken branch or
// jump from the branch comparator redirects fetch and squashes any
// wrong-path instruction that is in flight or already held.
//
// Parameters
//   RESET_PC          fetch address after reset (word aligned)
//   NOP_INSTR         word shown on o_if_instr after reset and after a squash
//
// Ports
//   i_clk             clock, rising edge
//   i_rst_n           asynchronous reset, active low
//   i_pc_sel          redirect request (branch/jump taken)
//   i_br_target       redirect address, used when i_pc_sel=1
//   i_stall           decode cannot accept o_if_* this cycle
//   o_imem_req_valid  fetch request valid
//   i_imem_req_ready  imem accepts the request
//   o_imem_addr       fetch address (word aligned)
//   i_imem_rsp_valid  imem response valid
//   i_imem_rsp_data   instruction word returned by imem
//   o_if_valid        o_if_pc/o_if_instr hold a valid instruction
//   o_if_pc           PC of the held instruction
//   o_if_instr        held instruction word

module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_pc_sel,
   input  logic [31:0] i_br_target,
   input  logic        i_stall,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_rsp_valid,
   input  logic [31:0] i_imem_rsp_data,
   output logic        o_if_valid,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_instr
);

   typedef enum logic [0:0] {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_req_pc;
   logic [31:0] w_req_pc_nxt;
   logic        r_drop;
   logic        w_drop_nxt;
   logic        r_if_valid;
   logic        w_if_valid_nxt;
   logic [31:0] r_if_pc;
   logic [31:0] w_if_pc_nxt;
   logic [31:0] r_if_instr;
   logic [31:0] w_if_instr_nxt;
   logic        w_req_want;
   logic        w_req_fire;

   // A request is offered only when the output slot is empty or is being
   // drained this cycle, so a response can never land on an unconsumed
   // instruction. The reset gate keeps the request low while reset is held;
   // the state registers themselves are frozen by the async reset.
   assign w_req_want       = (r_state == S_REQ) && (!r_if_valid || !i_stall);
   assign w_req_fire       = w_req_want && i_imem_req_ready;
   assign o_imem_req_valid = w_req_want && i_rst_n;
   assign o_imem_addr      = r_pc;

   assign o_if_valid = r_if_valid;
   assign o_if_pc    = r_if_pc;
   assign o_if_instr = r_if_instr;

   // Next-state logic. The normal fetch flow is worked out first and a
   // redirect is layered on top of it so it always wins, even over a stall.
   // The drop flag marks the single outstanding request as wrong-path so its
   // response is thrown away when it eventually arrives.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_req_pc_nxt   = r_req_pc;
      w_drop_nxt     = r_drop;
      w_if_valid_nxt = r_if_valid;
      w_if_pc_nxt    = r_if_pc;
      w_if_instr_nxt = r_if_instr;

      if (r_if_valid && !i_stall) begin
         w_if_valid_nxt = 1'b0;
      end

      case (r_state)
         S_REQ: begin
            if (w_req_fire) begin
               w_req_pc_nxt = r_pc;
               w_pc_nxt     = r_pc + 32'd4;
               w_state_nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_imem_rsp_valid) begin
               w_state_nxt = S_REQ;
               if (r_drop) begin
                  w_drop_nxt = 1'b0;
               end else begin
                  w_if_valid_nxt = 1'b1;
                  w_if_pc_nxt    = r_req_pc;
                  w_if_instr_nxt = i_imem_rsp_data;
               end
            end
         end
         default: begin
            w_state_nxt = S_REQ;
         end
      endcase

      // Redirect: the target replaces the fetch PC outright (a request
      // completing this same edge must not bump it to target+4), the held
      // instruction is squashed, and whatever is still in flight is marked
      // for dropping. A response arriving this very cycle is simply not
      // loaded, so no drop is needed for it.
      if (i_pc_sel) begin
         w_pc_nxt       = i_br_target & ~32'h0000_0003;
         w_if_valid_nxt = 1'b0;
         w_if_pc_nxt    = r_if_pc;
         w_if_instr_nxt = NOP_INSTR;
         if (r_state == S_WAIT) begin
            w_drop_nxt = !i_imem_rsp_valid;
         end else if (w_req_fire) begin
            w_drop_nxt = 1'b1;
         end
      end
   end

   // State and datapath registers. Reset discards everything, including any
   // notion of an outstanding request, so a late response lands in S_REQ
   // and is ignored.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_REQ;
         r_pc       <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_drop     <= 1'b0;
         r_if_valid <= 1'b0;
         r_if_pc    <= RESET_PC;
         r_if_instr <= NOP_INSTR;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_req_pc   <= w_req_pc_nxt;
         r_drop     <= w_drop_nxt;
         r_if_valid <= w_if_valid_nxt;
         r_if_pc    <= w_if_pc_nxt;
         r_if_instr <= w_if_instr_nxt;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit. A behavioural instruction memory answers
// each accepted request after a programmable number of cycles. Each test
// lists the fetch addresses and decode-side instructions it expects; a
// separate monitor compares whatever the DUT presents to decode against the
// expected queue.

module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_pc_sel;
   logic [31:0] i_br_target;
   logic        i_stall;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [31:0] o_imem_addr;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        o_if_valid;
   logic [31:0] o_if_pc;
   logic [31:0] o_if_instr;

   int          total = 0;
   int          bad   = 0;

   logic [31:0] addrQ[$];
   logic [63:0] outQ[$];

   int          rspLatency;
   logic        pend;
   logic [31:0] pendAddr;
   int          pendCnt;

   pc_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_pc_sel         (i_pc_sel),
      .i_br_target      (i_br_target),
      .i_stall          (i_stall),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_addr      (o_imem_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_data  (i_imem_rsp_data),
      .o_if_valid       (o_if_valid),
      .o_if_pc          (o_if_pc),
      .o_if_instr       (o_if_instr)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 i_clk = ~i_clk;

   // Contents of the behavioural instruction memory.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'hC0DE_0013;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expectAddr(input logic [31:0] a);
      addrQ.push_back(a);
   endtask

   task automatic expectOut(input logic [31:0] pc);
      outQ.push_back({pc, memWord(pc)});
   endtask

   // One clock cycle. Called just after a falling edge with the inputs for
   // this cycle already set: records a request handshake, then after the
   // rising edge drives the memory response for the following cycle.
   task automatic applyStimulus();
      #1;
      if (o_imem_req_valid && i_imem_req_ready) begin
         if (addrQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_req: got addr 0x%08h expected no request", o_imem_addr);
         end else begin
            checkOutput("imem_addr", o_imem_addr, addrQ.pop_front());
         end
         pend     = 1'b1;
         pendAddr = o_imem_addr;
         pendCnt  = rspLatency;
      end
      if (o_if_valid && i_stall) begin
         checkOutput("no_req_while_stalled", {31'd0, o_imem_req_valid}, 32'd0);
      end
      @(posedge i_clk);
      #1;
      i_imem_rsp_valid = 1'b0;
      if (pend) begin
         pendCnt--;
         if (pendCnt <= 0) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = memWord(pendAddr);
            pend             = 1'b0;
         end
      end
      @(negedge i_clk);
   endtask

   // Holds reset for two cycles and checks the reset values while held.
   task automatic doReset(input int lat, input logic rdy);
      i_rst_n          = 1'b0;
      i_pc_sel         = 1'b0;
      i_br_target      = 32'd0;
      i_stall          = 1'b0;
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = 32'd0;
      i_imem_req_ready = rdy;
      rspLatency       = lat;
      pend             = 1'b0;
      addrQ.delete();
      outQ.delete();
      applyStimulus();
      checkOutput("rst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
      checkOutput("rst_if_valid", {31'd0, o_if_valid}, 32'd0);
      checkOutput("rst_if_pc", o_if_pc, RESET_PC);
      checkOutput("rst_if_instr", o_if_instr, NOP);
      applyStimulus();
   endtask

   task automatic waitForPc(input logic [31:0] pc);
      int n = 0;
      while (!(o_if_valid && o_if_pc == pc) && n < 50) begin
         applyStimulus();
         n++;
      end
      total++;
      if (n >= 50) begin
         bad++;
         $display("[TB] FAIL wait_pc: got no valid pc 0x%08h expected within 50 cycles", pc);
      end
   endtask

   // Runs until every expected request is issued, then stops the memory
   // and lets the last responses drain through decode.
   task automatic runUntilDrained(input string name);
      int n = 0;
      while (addrQ.size() > 0 && n < 200) begin
         applyStimulus();
         n++;
      end
      if (addrQ.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL %s_reqs: got %0d requests missing expected 0", name, addrQ.size());
      end
      i_imem_req_ready = 1'b0;
      repeat (8) applyStimulus();
      total++;
      if (outQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL %s_drain: got %0d instructions missing expected 0", name, outQ.size());
      end
   endtask

   // Monitor: whenever decode sees a valid instruction it must equal the
   // head of the expected queue; it leaves the queue when decode takes it
   // or when a redirect squashes it.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge i_clk);
         #2;
         if (i_rst_n === 1'b1 && o_if_valid === 1'b1) begin
            if (outQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_if: got pc 0x%08h instr 0x%08h expected none", o_if_pc, o_if_instr);
            end else begin
               e = outQ[0];
               checkOutput("if_pc", o_if_pc, e[63:32]);
               checkOutput("if_instr", o_if_instr, e[31:0]);
               if (!i_stall || i_pc_sel) begin
                  void'(outQ.pop_front());
               end
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Sequential fetch from reset, then a 3-cycle stall on the held 0x8.
      doReset(1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         expectAddr(32'h4 * i);
         expectOut(32'h4 * i);
      end
      i_rst_n = 1'b1;
      waitForPc(32'h8);
      i_stall = 1'b1;
      repeat (3) applyStimulus();
      i_stall = 1'b0;
      runUntilDrained("seq_stall");

      // Redirect while waiting, response two cycles later is dropped.
      doReset(2, 1'b1);
      expectAddr(32'h0);
      expectAddr(32'h100);
      expectAddr(32'h104);
      expectOut(32'h100);
      expectOut(32'h104);
      i_rst_n = 1'b1;
      applyStimulus();
      i_pc_sel    = 1'b1;
      i_br_target = 32'h100;
      applyStimulus();
      i_pc_sel = 1'b0;
      runUntilDrained("redir_wait");

      // Redirect in the same cycle as the response.
      doReset(1, 1'b1);
      expectAddr(32'h0);
      expectAddr(32'h100);
      expectAddr(32'h104);
      expectOut(32'h100);
      expectOut(32'h104);
      i_rst_n = 1'b1;
      applyStimulus();
      i_pc_sel    = 1'b1;
      i_br_target = 32'h100;
      applyStimulus();
      i_pc_sel = 1'b0;
      runUntilDrained("redir_rsp");

      // Redirect in the same cycle as the request handshake.
      doReset(1, 1'b1);
      expectAddr(32'h0);
      expectAddr(32'h100);
      expectAddr(32'h104);
      expectOut(32'h100);
      expectOut(32'h104);
      i_rst_n     = 1'b1;
      i_pc_sel    = 1'b1;
      i_br_target = 32'h100;
      applyStimulus();
      i_pc_sel = 1'b0;
      runUntilDrained("redir_hs");

      // Address wrap from the top of memory.
      doReset(1, 1'b0);
      expectAddr(32'hFFFF_FFFC);
      expectAddr(32'h0);
      expectAddr(32'h4);
      expectOut(32'hFFFF_FFFC);
      expectOut(32'h0);
      expectOut(32'h4);
      i_rst_n     = 1'b1;
      i_pc_sel    = 1'b1;
      i_br_target = 32'hFFFF_FFFC;
      applyStimulus();
      i_pc_sel         = 1'b0;
      i_imem_req_ready = 1'b1;
      runUntilDrained("wrap");

      // Misaligned target is forced to a word boundary.
      doReset(1, 1'b0);
      expectAddr(32'h100);
      expectAddr(32'h104);
      expectOut(32'h100);
      expectOut(32'h104);
      i_rst_n     = 1'b1;
      i_pc_sel    = 1'b1;
      i_br_target = 32'h103;
      applyStimulus();
      i_pc_sel         = 1'b0;
      i_imem_req_ready = 1'b1;
      runUntilDrained("align");

      // Redirect overrides a stall and squashes the held instruction.
      doReset(1, 1'b1);
      expectAddr(32'h0);
      expectAddr(32'h4);
      expectAddr(32'h200);
      expectAddr(32'h204);
      expectOut(32'h0);
      expectOut(32'h4);
      expectOut(32'h200);
      expectOut(32'h204);
      i_rst_n = 1'b1;
      waitForPc(32'h4);
      i_stall     = 1'b1;
      i_pc_sel    = 1'b1;
      i_br_target = 32'h200;
      applyStimulus();
      i_pc_sel = 1'b0;
      i_stall  = 1'b0;
      checkOutput("squash_valid", {31'd0, o_if_valid}, 32'd0);
      checkOutput("squash_instr", o_if_instr, NOP);
      runUntilDrained("squash");

      // Reset pulsed while waiting; the late response must be ignored.
      doReset(3, 1'b1);
      expectAddr(32'h0);
      expectAddr(32'h0);
      expectOut(32'h0);
      i_rst_n = 1'b1;
      applyStimulus();
      i_rst_n          = 1'b0;
      i_imem_req_ready = 1'b0;
      #1;
      checkOutput("midrst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
      checkOutput("midrst_if_valid", {31'd0, o_if_valid}, 32'd0);
      checkOutput("midrst_if_pc", o_if_pc, RESET_PC);
      checkOutput("midrst_if_instr", o_if_instr, NOP);
      applyStimulus();
      i_rst_n = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("late_rsp_ignored", {31'd0, o_if_valid}, 32'd0);
      rspLatency       = 1;
      i_imem_req_ready = 1'b1;
      runUntilDrained("midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
